ir_nec_tx: RTL and testbench

//  NEC-format IR transmitter, the send side of the team's IR receiver (ir_rx).

---
 rtl/ir_nec_pkg.sv | 29 ++
 rtl/ir_carrier_gen.sv | 44 ++++
 rtl/ir_nec_tx.sv | 143 ++++++++++++++
 tb/tb_ir_nec_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC IR timing constants and FSM state encoding.
// Imported by both the transmitter (ir_nec_tx) and the receiver (ir_rx).
package ir_nec_pkg;

  // Nominal protocol timing in microseconds and the 50 MHz system clock rate
  localparam int unsigned NEC_CLK_PER_US    = 50;
  localparam int unsigned NEC_LEAD_MARK_US  = 9000;
  localparam int unsigned NEC_LEAD_SPACE_US = 4500;
  localparam int unsigned NEC_BIT_MARK_US   = 560;
  localparam int unsigned NEC_ZERO_SPACE_US = 560;
  localparam int unsigned NEC_ONE_SPACE_US  = 1690;
  localparam int unsigned NEC_GAP_US        = 40000;
  localparam int unsigned NEC_CARRIER_DIV   = 1316;

  // Frame sequencing states
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
  localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
  localparam logic [2:0] ST_BIT_MARK   = 3'd3;
  localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
  localparam logic [2:0] ST_STOP_MARK  = 3'd5;
  localparam logic [2:0] ST_GAP        = 3'd6;

  // True for the states in which the IR envelope is a mark (LED on)
  function automatic logic is_mark_state(input logic [2:0] st);
    return (st == ST_LEAD_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase generator for the IR LED drive.
// i_en is the envelope value for the *next* cycle, so o_carrier comes out of a
// register already gated and aligned with the registered envelope in the top.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int unsigned DIV = NEC_CARRIER_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_carrier
);

  localparam logic [15:0] LAST = 16'(DIV - 1);
  localparam logic [15:0] HALF = 16'(DIV / 2);

  logic [15:0] phase;
  logic [15:0] phase_nxt;
  logic        en_q;

  // Phase for the coming cycle: restarts at 0 on every mark so each mark opens
  // with a full high half-period, otherwise counts 0..DIV-1 and wraps
  always_comb begin
    phase_nxt = '0;
    if (i_en && en_q) begin
      phase_nxt = (phase == LAST) ? '0 : phase + 16'd1;
    end
  end

  // Phase counter and gated carrier output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      en_q      <= 1'b0;
      o_carrier <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      en_q      <= i_en;
      o_carrier <= i_en && (phase_nxt < HALF);
    end
  end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC-format IR transmitter: lead mark, lead space, 32 bit cells (MSB first),
// stop mark and an inter-frame gap. Drives the plain envelope, the carrier
// modulated LED drive and an inverted envelope for loopback into ir_rx.
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned CLK_PER_US    = NEC_CLK_PER_US,
  parameter int unsigned LEAD_MARK_US  = NEC_LEAD_MARK_US,
  parameter int unsigned LEAD_SPACE_US = NEC_LEAD_SPACE_US,
  parameter int unsigned BIT_MARK_US   = NEC_BIT_MARK_US,
  parameter int unsigned ZERO_SPACE_US = NEC_ZERO_SPACE_US,
  parameter int unsigned ONE_SPACE_US  = NEC_ONE_SPACE_US,
  parameter int unsigned GAP_US        = NEC_GAP_US,
  parameter int unsigned CARRIER_DIV   = NEC_CARRIER_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ir_env,
  output logic        o_ir_mod,
  output logic        o_ir_txb
);

  // Counter reload values: a state lasting N cycles loads N-1 and leaves at 0.
  // Products are formed in 32-bit arithmetic before narrowing to 24 bits.
  localparam logic [23:0] LEAD_MARK_LD  = 24'(LEAD_MARK_US * CLK_PER_US - 1);
  localparam logic [23:0] LEAD_SPACE_LD = 24'(LEAD_SPACE_US * CLK_PER_US - 1);
  localparam logic [23:0] BIT_MARK_LD   = 24'(BIT_MARK_US * CLK_PER_US - 1);
  localparam logic [23:0] ZERO_SPACE_LD = 24'(ZERO_SPACE_US * CLK_PER_US - 1);
  localparam logic [23:0] ONE_SPACE_LD  = 24'(ONE_SPACE_US * CLK_PER_US - 1);
  localparam logic [23:0] GAP_LD        = 24'(GAP_US * CLK_PER_US - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [23:0] dur_cnt;
  logic [23:0] dur_cnt_nxt;
  logic [31:0] shreg;
  logic [31:0] shreg_nxt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_cnt_nxt;
  logic        env_nxt;
  logic        carrier;

  // Next-state, duration counter, shift register and bit counter logic
  always_comb begin
    state_nxt   = state;
    dur_cnt_nxt = dur_cnt;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    if (state != ST_IDLE && dur_cnt != 24'd0) begin
      dur_cnt_nxt = dur_cnt - 24'd1;
    end else begin
      case (state)
        ST_IDLE: begin
          dur_cnt_nxt = '0;
          if (i_start) begin
            state_nxt   = ST_LEAD_MARK;
            dur_cnt_nxt = LEAD_MARK_LD;
            shreg_nxt   = i_data;
          end
        end
        ST_LEAD_MARK: begin
          state_nxt   = ST_LEAD_SPACE;
          dur_cnt_nxt = LEAD_SPACE_LD;
        end
        ST_LEAD_SPACE: begin
          state_nxt   = ST_BIT_MARK;
          dur_cnt_nxt = BIT_MARK_LD;
          bit_cnt_nxt = '0;
        end
        ST_BIT_MARK: begin
          state_nxt   = ST_BIT_SPACE;
          dur_cnt_nxt = shreg[31] ? ONE_SPACE_LD : ZERO_SPACE_LD;
        end
        ST_BIT_SPACE: begin
          shreg_nxt   = {shreg[30:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 6'd1;
          state_nxt   = (bit_cnt == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
          dur_cnt_nxt = BIT_MARK_LD;
        end
        ST_STOP_MARK: begin
          state_nxt   = ST_GAP;
          dur_cnt_nxt = GAP_LD;
        end
        ST_GAP: begin
          state_nxt   = ST_IDLE;
          dur_cnt_nxt = '0;
        end
        default: begin
          state_nxt   = ST_IDLE;
          dur_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign env_nxt = is_mark_state(state_nxt);

  // FSM and datapath state registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      dur_cnt <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dur_cnt <= dur_cnt_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Registered outputs, computed from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_ir_env <= 1'b0;
      o_ir_txb <= 1'b1;
    end else begin
      o_busy   <= (state_nxt != ST_IDLE);
      o_done   <= (state_nxt == ST_GAP) && (dur_cnt_nxt == 24'd0);
      o_ir_env <= env_nxt;
      o_ir_txb <= ~env_nxt;
    end
  end

  ir_carrier_gen #(
    .DIV (CARRIER_DIV)
  ) u_carrier (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (env_nxt),
    .o_carrier (carrier)
  );

  assign o_ir_mod = carrier;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx. Timing is scaled down (2 clk/us and short
// durations) so whole frames fit in a few hundred cycles. A monitor decodes the
// envelope into runs, rebuilds the word and timing, and compares against the
// expectations queued by the stimulus process when o_done pulses.
module tb_ir_nec_tx;

  // Hand-computed cycle counts for the scaled parameter set below
  localparam int LEAD_MARK_CLKS  = 18;
  localparam int LEAD_SPACE_CLKS = 8;
  localparam int BIT_MARK_CLKS   = 2;
  localparam int ZERO_SPACE_CLKS = 2;
  localparam int ONE_SPACE_CLKS  = 6;
  localparam int STOP_MARK_CLKS  = 2;
  localparam int GAP_CLKS        = 20;
  localparam int CAR_PERIOD      = 6;
  localparam int CAR_HIGH        = 3;
  localparam int FRAME_RUNS      = 67;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_ir_env;
  logic        o_ir_mod;
  logic        o_ir_txb;

  typedef struct {
    logic [31:0] word;
    int          frame_len;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_total = 0;

  ir_nec_tx #(
    .CLK_PER_US    (2),
    .LEAD_MARK_US  (9),
    .LEAD_SPACE_US (4),
    .BIT_MARK_US   (1),
    .ZERO_SPACE_US (1),
    .ONE_SPACE_US  (3),
    .GAP_US        (10),
    .CARRIER_DIV   (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_data   (i_data),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ir_env (o_ir_env),
    .o_ir_mod (o_ir_mod),
    .o_ir_txb (o_ir_txb)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One-cycle start pulse with the given word
  task automatic apply_stimulus(input logic [31:0] word);
    @(negedge clk);
    i_data  = word;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Wait (bounded) for the transmitter to drop busy
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  // Monitor state
  int          runs[$];
  logic        cur_level = 1'b0;
  int          run_len = 0;
  bit          in_frame = 1'b0;
  bit          saw_frame = 1'b0;
  int          car_err = 0;
  int          bit_err;
  int          frame_len;
  logic [31:0] dec_word;
  logic        exp_mod;
  exp_t        e;

  // Monitor: split the envelope into runs, check carrier/txb every cycle and
  // score the whole frame when o_done appears
  always @(negedge clk) begin
    if (!rst_n) begin
      runs.delete();
      cur_level = 1'b0;
      run_len   = 0;
      in_frame  = 1'b0;
      saw_frame = 1'b0;
      car_err   = 0;
    end else begin
      if (o_ir_env == cur_level) begin
        run_len++;
      end else begin
        if (in_frame) begin
          runs.push_back(run_len);
        end else if (o_ir_env) begin
          if (saw_frame) check_output("interframe_space", 32'(run_len >= GAP_CLKS), 32'd1);
          in_frame = 1'b1;
          runs.delete();
          car_err = 0;
        end
        cur_level = o_ir_env;
        run_len   = 1;
      end

      if (in_frame) begin
        exp_mod = o_ir_env && (((run_len - 1) % CAR_PERIOD) < CAR_HIGH);
        if (o_ir_mod !== exp_mod || o_ir_txb !== ~o_ir_env) car_err++;
      end

      if (o_done) begin
        done_total++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_output("run_count", 32'(runs.size()), 32'(FRAME_RUNS));
          check_output("busy_at_done", 32'(o_busy), 32'd1);
          if (runs.size() == FRAME_RUNS) begin
            frame_len = 0;
            foreach (runs[i]) frame_len += runs[i];
            dec_word = '0;
            bit_err  = 0;
            for (int i = 0; i < 32; i++) begin
              if (runs[2 + 2 * i] != BIT_MARK_CLKS) bit_err++;
              if (runs[3 + 2 * i] == ONE_SPACE_CLKS) begin
                dec_word = {dec_word[30:0], 1'b1};
              end else if (runs[3 + 2 * i] == ZERO_SPACE_CLKS) begin
                dec_word = {dec_word[30:0], 1'b0};
              end else begin
                bit_err++;
                dec_word = {dec_word[30:0], 1'b0};
              end
            end
            check_output("word", dec_word, e.word);
            check_output("frame_len", 32'(frame_len), 32'(e.frame_len));
            check_output("lead_mark", 32'(runs[0]), 32'(LEAD_MARK_CLKS));
            check_output("lead_space", 32'(runs[1]), 32'(LEAD_SPACE_CLKS));
            check_output("bit_cells", 32'(bit_err), 32'd0);
            check_output("stop_mark", 32'(runs[FRAME_RUNS - 1]), 32'(STOP_MARK_CLKS));
            check_output("gap_len", 32'(run_len), 32'(GAP_CLKS));
            check_output("carrier_txb", 32'(car_err), 32'd0);
          end
        end
        in_frame  = 1'b0;
        saw_frame = 1'b1;
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    int n_done;
    int cyc;
    int bad;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_done", 32'(o_done), 32'd0);
    check_output("rst_env", 32'(o_ir_env), 32'd0);
    check_output("rst_mod", 32'(o_ir_mod), 32'd0);
    check_output("rst_txb", 32'(o_ir_txb), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback word: 16 ones -> 26 + 64 + 16*6 + 16*2 + 2 = 220
    exp_q.push_back('{32'h00FF_A25D, 220});
    apply_stimulus(32'h00FF_A25D);
    check_output("env_after_accept", 32'(o_ir_env), 32'd1);
    check_output("busy_after_accept", 32'(o_busy), 32'd1);
    wait_idle("frame1_idle");

    // All ones: 26 + 64 + 32*6 + 2 = 284
    exp_q.push_back('{32'hFFFF_FFFF, 284});
    apply_stimulus(32'hFFFF_FFFF);
    wait_idle("frame2_idle");

    // Start pulse inside bit 0's space must be ignored: 9 ones -> 192
    exp_q.push_back('{32'hC3C3_0001, 192});
    apply_stimulus(32'hC3C3_0001);
    repeat (28) @(negedge clk);
    i_data  = 32'h1234_5678;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle("frame3_idle");
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_ir_env || o_busy) bad++;
    end
    check_output("no_second_frame", 32'(bad), 32'd0);

    // Held start, all-zero word: three back-to-back frames of 156 cycles
    repeat (3) exp_q.push_back('{32'h0000_0000, 156});
    @(negedge clk);
    i_data  = 32'h0000_0000;
    i_start = 1'b1;
    n_done = 0;
    cyc    = 0;
    while (n_done < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (o_done) n_done++;
    end
    i_start = 1'b0;
    check_output("held_frames", 32'(n_done), 32'd3);
    wait_idle("held_idle");

    // Reset asserted during bit 17 aborts at once
    apply_stimulus(32'h0000_0000);
    repeat (96) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_env", 32'(o_ir_env), 32'd0);
    check_output("abort_txb", 32'(o_ir_txb), 32'd1);
    check_output("abort_busy", 32'(o_busy), 32'd0);
    check_output("abort_mod", 32'(o_ir_mod), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_ir_env || o_busy || o_done || o_ir_mod || !o_ir_txb) bad++;
    end
    check_output("idle_after_reset", 32'(bad), 32'd0);

    // Fresh frame after reset: 2 ones -> 26 + 64 + 12 + 60 + 2 = 164
    exp_q.push_back('{32'h8000_0001, 164});
    apply_stimulus(32'h8000_0001);
    wait_idle("frame_post_reset_idle");

    repeat (5) @(negedge clk);
    check_output("done_total", 32'(done_total), 32'd7);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute bound on simulation time
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
